serial_adder: RTL

- Parametrised, digit-serial successor to the single-bit full adder.
- Adds or subtracts two WIDTH-bit operands over WIDTH/DIGIT cycles.
- Each cycle it processes DIGIT bits through a ripple chain of full-adder cells and carries between cycles in a register.
- Serves as an area-cheap arithmetic unit behind a start/busy/done handshake for datapaths that tolerate multi-cycle latency.

---
 rtl/serial_adder_pkg.sv | 4 +
 rtl/serial_adder_digit.sv | 20 ++
 rtl/serial_adder.sv | 95 +++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types for the digit-serial adder.
package serial_adder_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/serial_adder_digit.sv
// adder_digit: N-bit ripple of full-adder cells, also exposing the carry into the top bit.
module adder_digit #(
   parameter int N = 1
) (
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   input  logic         ci,
   output logic [N-1:0] s,
   output logic         co,
   output logic         c_msb
);
   logic [N:0] c;
   assign c[0] = ci;
   for (genvar i = 0; i < N; i++) begin : g_bit
      assign s[i]   = x[i] ^ y[i] ^ c[i];
      assign c[i+1] = (x[i] & y[i]) | ((x[i] | y[i]) & c[i]);
   end
   assign co    = c[N];
   assign c_msb = c[N-1];
endmodule

// File: rtl/serial_adder.sv
// serial_adder: digit-serial add/subtract of two WIDTH-bit operands, DIGIT bits per cycle,
// behind a start/busy/done handshake.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int STEPS = WIDTH / DIGIT;
   localparam int CW    = STEPS > 1 ? $clog2(STEPS) : 1;

   if (DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad_digit
      $error("serial_adder: DIGIT must divide WIDTH");
   end

   state_t           state;
   logic [WIDTH-1:0] ra, rb, acc, nxt;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic [DIGIT-1:0] ds;
   logic             dco, dmsb;

   adder_digit #(.N(DIGIT)) u_digit (
      .x    (ra[DIGIT-1:0]),
      .y    (rb[DIGIT-1:0]),
      .ci   (carry),
      .s    (ds),
      .co   (dco),
      .c_msb(dmsb)
   );

   // result digits enter from the MSB side, so after STEPS shifts acc is LSB-aligned
   assign nxt = WIDTH'({ds, acc} >> DIGIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
         ra    <= '0;
         rb    <= '0;
         acc   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            RUN: begin
               acc   <= nxt;
               ra    <= ra >> DIGIT;
               rb    <= rb >> DIGIT;
               carry <= dco;
               if (cnt == '0) begin
                  sum   <= nxt;
                  cout  <= dco;
                  ovf   <= dco ^ dmsb;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               if (start) begin
                  ra    <= a;
                  rb    <= sub ? ~b : b;
                  carry <= sub ^ cin;
                  cnt   <= CW'(STEPS - 1);
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end
endmodule
